// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer:
// opcodes, FSM states and the initial-carry rule.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_RSUB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic init_carry(
        input logic [2:0] op,
        input logic       cin
    );
        logic c;
        c = 1'b0;
        case (op)
            OP_INC, OP_SUB, OP_RSUB: c = 1'b1;
            OP_ADD:                  c = cin;
            default:                 c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu1b.sv
// ALU1b: one-bit ALU slice. M selects arithmetic; S1,S0
// pick the logic function or the operand inversion.
module alu1b (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic m_i,
    input  logic s1_i,
    input  logic s0_i,
    output logic f_o,
    output logic co_o
);

    logic x;
    logic y;

    always_comb begin
        x    = a_i;
        y    = b_i;
        f_o  = 1'b0;
        co_o = 1'b0;
        if (m_i) begin
            case ({s1_i, s0_i})
                2'b00:   y = 1'b0;
                2'b01:   y = b_i;
                2'b10:   y = ~b_i;
                default: x = ~a_i;
            endcase
            f_o  = x ^ y ^ c_i;
            co_o = (x & y) | (c_i & (x ^ y));
        end else begin
            case ({s1_i, s0_i})
                2'b00:   f_o = a_i & b_i;
                2'b01:   f_o = a_i | b_i;
                2'b10:   f_o = a_i ^ b_i;
                default: f_o = ~(a_i ^ b_i);
            endcase
        end
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one WIDTH-bit op, LSB first,
// through a single ALU1b slice with the carry fed back.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             zero_o
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             f;
    logic             co;

    alu1b u_slice (
        .a_i  (sa_q[0]),
        .b_i  (sb_q[0]),
        .c_i  (carry_q),
        .m_i  (op_q[2]),
        .s1_i (op_q[1]),
        .s0_i (op_q[0]),
        .f_o  (f),
        .co_o (co)
    );

    assign sr_d = {f, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q    <= op_i;
                        sa_q    <= a_i;
                        sb_q    <= b_i;
                        carry_q <= init_carry(op_i, cin_i);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    sr_q    <= sr_d;
                    carry_q <= co;
                    cnt_q   <= cnt_q + 1'b1;
                    // Last bit: publish the completed word.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= sr_d;
                        cout_q   <= op_q[2] & co;
                        zero_q   <= (sr_d == '0);
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8) against
// an arithmetic reference model with cycle-level timing.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         cout_o;
    logic         zero_o;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cin_i    (cin_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .zero_o   (zero_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference result: {cout, result} from plain arithmetic.
    function automatic logic [W:0] ref_op(input logic [2:0] op,
        input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        logic [W:0] ea;
        logic [W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (op)
            3'd0: s = {1'b0, a & b};
            3'd1: s = {1'b0, a | b};
            3'd2: s = {1'b0, a ^ b};
            3'd3: s = {1'b0, ~(a ^ b)};
            3'd4: s = ea + 1;
            3'd5: s = ea + eb + {{W{1'b0}}, c};
            3'd6: s = ea + {1'b0, ~b} + 1;
            default: s = {1'b0, ~a} + eb + 1;
        endcase
        return s;
    endfunction

    // Timing model: an accepted op finishes W edges later,
    // then one more edge of DONE before a new start is taken.
    int           m_timer;
    logic         m_busy, m_done, m_cout, m_zero, p_cout;
    logic [W-1:0] m_res, p_res;

    always @(posedge clk) begin
        if (rst) begin
            m_timer = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res = '0;
            m_cout = 1'b0;
            m_zero = 1'b1;
        end else if (m_timer == 0) begin
            m_done = 1'b0;
            if (start_i) begin
                {p_cout, p_res} = ref_op(op_i, a_i, b_i, cin_i);
                m_timer = W + 1;
                m_busy = 1'b1;
            end
        end else begin
            m_timer--;
            if (m_timer == 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res = p_res;
                m_cout = p_cout;
                m_zero = (p_res == '0);
            end else begin
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", busy_o, m_busy);
            chk("cyc_done", done_o, m_done);
            chk("cyc_result", result_o, m_res);
            chk("cyc_cout", cout_o, m_cout);
            chk("cyc_zero", zero_o, m_zero);
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
        input logic [W-1:0] b, input logic c, input bit lit,
        input logic [W-1:0] er, input logic ec, input string nm);
        int n;
        int nb;
        logic [W:0] mr;
        @(negedge clk);
        op_i = op;
        a_i = a;
        b_i = b;
        cin_i = c;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i = W'($urandom);
        b_i = W'($urandom);
        cin_i = 1'($urandom);
        n = 1;
        nb = busy_o ? 1 : 0;
        while (!done_o && n < 4 * W) begin
            @(negedge clk);
            n++;
            if (busy_o) nb++;
        end
        chk({nm, "_latency"}, n, W + 1);
        chk({nm, "_busy_cycles"}, nb, W);
        if (lit) begin
            mr = ref_op(op, a, b, c);
            chk({nm, "_model"}, mr, {ec, er});
            chk({nm, "_result"}, result_o, er);
            chk({nm, "_cout"}, cout_o, ec);
            chk({nm, "_zero"}, zero_o, er == '0);
        end
    endtask

    initial begin
        int prev;
        int nd;
        int k;
        // Reset held with start asserted: start must be dropped.
        rst = 1'b1;
        start_i = 1'b1;
        op_i = 3'b101;
        a_i = 8'h12;
        b_i = 8'h34;
        repeat (2) @(negedge clk);
        start_i = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_zero", zero_o, 1);
        rst = 1'b0;
        chk_en = 1'b1;

        do_op(3'b101, 8'h5A, 8'h3C, 1'b0, 1, 8'h96, 1'b0, "add");
        do_op(3'b101, 8'hF0, 8'h0F, 1'b1, 1, 8'h00, 1'b1, "add_cin");
        do_op(3'b110, 8'h10, 8'h01, 1'b0, 1, 8'h0F, 1'b1, "sub1");
        do_op(3'b110, 8'h00, 8'h01, 1'b0, 1, 8'hFF, 1'b0, "sub2");
        do_op(3'b111, 8'h03, 8'h0A, 1'b0, 1, 8'h07, 1'b1, "rsub");
        do_op(3'b100, 8'hFF, 8'h5A, 1'b0, 1, 8'h00, 1'b1, "inc_wrap");
        do_op(3'b100, 8'h7F, 8'h00, 1'b1, 1, 8'h80, 1'b0, "inc");
        do_op(3'b000, 8'hF0, 8'h3C, 1'b1, 1, 8'h30, 1'b0, "and");
        do_op(3'b001, 8'hF0, 8'h0C, 1'b1, 1, 8'hFC, 1'b0, "or");
        do_op(3'b010, 8'hAA, 8'hFF, 1'b1, 1, 8'h55, 1'b0, "xor");
        do_op(3'b011, 8'hAA, 8'h55, 1'b1, 1, 8'h00, 1'b0, "xnor");

        // start_i held high: one op every W+2 cycles.
        @(negedge clk);
        op_i = 3'b101;
        a_i = 8'h01;
        b_i = 8'h02;
        cin_i = 1'b0;
        start_i = 1'b1;
        prev = -1;
        nd = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (done_o) begin
                if (prev >= 0) chk("b2b_gap", c - prev, W + 2);
                prev = c;
                nd++;
            end
        end
        start_i = 1'b0;
        chk("b2b_count", nd, 3);
        repeat (12) @(negedge clk);

        // A start pulse mid-RUN is ignored.
        op_i = 3'b101;
        a_i = 8'h11;
        b_i = 8'h22;
        cin_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        op_i = 3'b110;
        a_i = 8'h99;
        b_i = 8'h01;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 0;
        while (!done_o && k < 4 * W) begin
            @(negedge clk);
            k++;
        end
        chk("midrun_result", result_o, 8'h33);
        repeat (3) @(negedge clk);
        chk("midrun_no_second", busy_o, 0);

        // Reset on RUN cycle 4 aborts with no done pulse.
        op_i = 3'b101;
        a_i = 8'hFF;
        b_i = 8'h01;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_result", result_o, 0);
        chk("abort_zero", zero_o, 1);
        nd = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        chk("abort_no_done", nd, 0);
        do_op(3'b101, 8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0, "post_abort");

        for (int i = 0; i < 150; i++) begin
            do_op(3'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), 0, '0, 1'b0, "rand");
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
